atri_samplemon_loader: RTL and testbench

Programs the 1024×18 sample-monitor PicoBlaze instruction RAM at run time from a host byte stream, replacing a firmware rebuild for every program change. Sits between the host register/command path and the write port of the dual-port program RAM, whose read port feeds the processor. The processor is held in reset while loading. The block packs bytes into 18-bit instructions, writes them at incrementing addresses, zero-fills unused locations, checksums the image and releases the processor.

---
 rtl/atri_samplemon_loader_pkg.sv | 16 +
 rtl/atri_samplemon_word_assembler.sv | 43 ++++
 rtl/atri_samplemon_loader.sv | 139 +++++++++++++
 tb/tb_atri_samplemon_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atri_samplemon_loader_pkg.sv
// Shared constants and state encoding for the sample-monitor program loader.
// PicoBlaze program RAM is 1024 x 18.
package atri_samplemon_loader_pkg;
   localparam int PROG_DEPTH  = 1024;
   localparam int INSTR_WIDTH = 18;
   localparam int ADDR_WIDTH  = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FILL,
      S_HOLD,
      S_DONE,
      S_ERROR
   } state_t;
endpackage

// File: rtl/atri_samplemon_word_assembler.sv
// Packs three host bytes (MSB first) into one 18-bit instruction word.
// Phase 0 byte may only carry the two top bits.
module atri_samplemon_word_assembler
   import atri_samplemon_loader_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   accept,
   input  logic [7:0]             data,
   output logic                   word_valid,
   output logic [INSTR_WIDTH-1:0] word,
   output logic                   phase_err,
   output logic [1:0]             phase
);
   logic [9:0] hi;

   assign phase_err  = accept && (phase == 2'd0) && (data[7:2] != 6'd0);
   assign word_valid = accept && (phase == 2'd2);
   assign word       = {hi, data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 2'd0;
         hi    <= '0;
      end else if (clear) begin
         phase <= 2'd0;
         hi    <= '0;
      end else if (accept && !phase_err) begin
         unique case (phase)
            2'd0: begin
               hi[9:8] <= data[1:0];
               phase   <= 2'd1;
            end
            2'd1: begin
               hi[7:0] <= data;
               phase   <= 2'd2;
            end
            default: phase <= 2'd0;
         endcase
      end
   end
endmodule

// File: rtl/atri_samplemon_loader.sv
// Run-time loader for the sample-monitor PicoBlaze program RAM.
// Holds the processor in reset until a complete image is written.
module atri_samplemon_loader
   import atri_samplemon_loader_pkg::*;
#(
   parameter bit FILL_UNUSED   = 1'b1,
   parameter int RELEASE_DELAY = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic        load_end,
   input  logic        data_valid,
   input  logic [7:0]  data,
   output logic        data_ready,
   output logic        ram_we,
   output logic [9:0]  ram_addr,
   output logic [17:0] ram_data,
   output logic        proc_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [17:0] checksum,
   output logic [10:0] word_count
);
   state_t      state, state_n;
   logic        accept;
   logic        word_valid, phase_err;
   logic [17:0] word;
   logic [1:0]  phase;
   logic [10:0] addr_next;
   logic [7:0]  hold_cnt;
   logic        wr_img, wr_fill;
   logic        full, end_ok;
   logic [10:0] words_after;

   assign data_ready = (state == S_LOAD);
   assign accept     = data_valid & data_ready;
   assign busy       = (state == S_LOAD) || (state == S_FILL) ||
                       (state == S_HOLD);
   assign done       = (state == S_DONE);
   assign error      = (state == S_ERROR);
   assign proc_reset = (state != S_DONE);

   assign full        = (word_count == 11'(PROG_DEPTH));
   assign words_after = word_count + 11'(word_valid);
   // image end is clean only on a word boundary with at least one word
   assign end_ok      = (word_valid || (!accept && phase == 2'd0)) &&
                        (words_after != 11'd0);

   atri_samplemon_word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (load_start),
      .accept     (accept),
      .data       (data),
      .word_valid (word_valid),
      .word       (word),
      .phase_err  (phase_err),
      .phase      (phase)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      wr_img  = 1'b0;
      wr_fill = 1'b0;
      unique case (state)
         S_LOAD: begin
            if (accept && (full || phase_err)) begin
               state_n = S_ERROR;
            end else begin
               wr_img = word_valid;
               if (load_end) begin
                  if (!end_ok)
                     state_n = S_ERROR;
                  else if (FILL_UNUSED && words_after < 11'(PROG_DEPTH))
                     state_n = S_FILL;
                  else
                     state_n = S_HOLD;
               end
            end
         end
         S_FILL: begin
            wr_fill = 1'b1;
            if (addr_next == 11'(PROG_DEPTH - 1)) state_n = S_HOLD;
         end
         S_HOLD: begin
            if (hold_cnt == 8'(RELEASE_DELAY - 1)) state_n = S_DONE;
         end
         default: ;
      endcase
      if (load_start) begin
         state_n = S_LOAD;
         wr_img  = 1'b0;
         wr_fill = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_data   <= '0;
         checksum   <= '0;
         word_count <= '0;
         addr_next  <= '0;
         hold_cnt   <= '0;
      end else begin
         ram_we <= wr_img | wr_fill;
         if (load_start) begin
            ram_addr   <= '0;
            checksum   <= '0;
            word_count <= '0;
            addr_next  <= '0;
            hold_cnt   <= '0;
         end else begin
            if (wr_img) begin
               ram_addr   <= addr_next[9:0];
               ram_data   <= word;
               checksum   <= checksum + word;
               word_count <= word_count + 11'd1;
               addr_next  <= addr_next + 11'd1;
            end
            if (wr_fill) begin
               ram_addr  <= addr_next[9:0];
               ram_data  <= '0;
               addr_next <= addr_next + 11'd1;
            end
            if (state == S_HOLD) hold_cnt <= hold_cnt + 8'd1;
            else                 hold_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_atri_samplemon_loader.sv
// Randomized scoreboard bench for atri_samplemon_loader.
// Expected RAM writes are queued by the model and popped by a monitor.
module tb_atri_samplemon_loader;
   localparam int RD    = 16;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic        load_end = 1'b0;
   logic        data_valid = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        data_ready, ram_we, proc_reset, busy, done, error;
   logic [9:0]  ram_addr;
   logic [17:0] ram_data, checksum;
   logic [10:0] word_count;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   bit gaps = 1'b1;

   logic [27:0] exp_q[$];
   int          addr_m;
   int          cnt_m;
   logic [17:0] sum_m;

   atri_samplemon_loader #(
      .FILL_UNUSED   (1'b1),
      .RELEASE_DELAY (RD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_end   (load_end),
      .data_valid (data_valid),
      .data       (data),
      .data_ready (data_ready),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .proc_reset (proc_reset),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .checksum   (checksum),
      .word_count (word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         last_we_cyc = cyc;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0d data %0h",
                     ram_addr, ram_data);
         end else begin
            logic [27:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(ram_addr), 32'(e[27:18]));
            check("wr_data", 32'(ram_data), 32'(e[17:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      addr_m = 0;
      cnt_m  = 0;
      sum_m  = '0;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_end);
      data_valid = 1'b1;
      data       = b;
      load_end   = with_end;
      step();
      data_valid = 1'b0;
      load_end   = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) step();
   endtask

   task automatic push_fill();
      while (addr_m < DEPTH) begin
         exp_q.push_back({10'(addr_m), 18'h0});
         addr_m++;
      end
   endtask

   task automatic send_word(input logic [17:0] w, input bit end_last);
      exp_q.push_back({10'(addr_m), w});
      addr_m++;
      cnt_m++;
      sum_m = sum_m + w;
      if (end_last && cnt_m < DEPTH) push_fill();
      send_byte({6'd0, w[17:16]}, 1'b0);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], end_last);
   endtask

   task automatic end_sep();
      if (cnt_m < DEPTH) push_fill();
      load_end = 1'b1;
      step();
      load_end = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            check("release_delay", 32'(cyc - last_we_cyc), 32'(RD));
            check("proc_reset_low", 32'(proc_reset), 32'd0);
         end
      end
      if (!seen) check("done_timeout", 32'(done), 32'd1);
      step();
   endtask

   task automatic check_status();
      check("word_count", 32'(word_count), 32'(cnt_m));
      check("checksum", 32'(checksum), 32'(sum_m));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #300ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #12;
      check("rst_proc_reset", 32'(proc_reset), 32'd1);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_flags", 32'({busy, done, error, data_ready}), 32'd0);
      check("rst_count", 32'(word_count), 32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);
      rst = 1'b0;
      step();

      // fixed three-word image, separate load_end, zero fill
      start_load();
      check("load_busy", 32'({busy, proc_reset, data_ready}), 32'h7);
      send_word(18'h3FFFF, 1'b0);
      send_word(18'h00001, 1'b0);
      send_word(18'h2A5A5, 1'b0);
      end_sep();
      wait_done();
      check_status();
      check("fixed_sum", 32'(checksum), 32'h2A5A5);
      check("done_flags", 32'({done, error, busy}), 32'h4);

      // random image, load_end with final byte
      start_load();
      check("start_clears_done", 32'({done, word_count}), 32'd0);
      n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++)
         send_word(18'($urandom), i == n - 1);
      wait_done();
      check_status();

      // bad phase-0 byte
      gaps = 1'b0;
      start_load();
      send_byte(8'h04, 1'b0);
      check("bad_byte_err", 32'({error, proc_reset, ram_we}), 32'h6);
      check("bad_byte_ready", 32'({busy, data_ready}), 32'd0);

      // load_end mid-word, then clean reload
      gaps = 1'b1;
      start_load();
      send_word(18'($urandom), 1'b0);
      send_byte(8'h01, 1'b0);
      load_end = 1'b1;
      step();
      load_end = 1'b0;
      check("midword_end_err", 32'(error), 32'd1);
      start_load();
      check("err_cleared", 32'({error, busy}), 32'h1);
      send_word(18'($urandom), 1'b0);
      send_word(18'($urandom), 1'b0);
      end_sep();
      wait_done();
      check_status();

      // load_end with no words
      start_load();
      load_end = 1'b1;
      step();
      load_end = 1'b0;
      check("empty_end_err", 32'(error), 32'd1);

      // full image plus one extra byte
      start_load();
      for (int i = 0; i < DEPTH; i++) send_word(18'($urandom), 1'b0);
      send_byte(8'h00, 1'b0);
      check("overflow_err", 32'({error, proc_reset}), 32'h3);
      step();
      check_status();

      // full image with load_end: no fill
      start_load();
      for (int i = 0; i < DEPTH; i++)
         send_word(18'($urandom), i == DEPTH - 1);
      wait_done();
      check_status();

      // async reset mid-load
      start_load();
      for (int i = 0; i < 10; i++) send_word(18'($urandom), 1'b0);
      send_byte(8'h02, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_proc", 32'(proc_reset), 32'd1);
      check("mid_rst_flags", 32'({busy, done, error, data_ready, ram_we}),
            32'd0);
      check("mid_rst_cnt", 32'({word_count, checksum}), 32'd0);
      check("mid_rst_addr", 32'(ram_addr), 32'd0);
      #3;
      rst = 1'b0;
      step();
      cnt_m = 0;
      sum_m = '0;
      for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 3)), i == 5);
      step();
      check("post_rst_idle", 32'({busy, done, error, proc_reset}), 32'h1);
      check_status();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
